// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: datapath width, M-extension operation codes
// (encoded as funct3) and the decoder operation list that feeds them.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  // M-extension entries sit at 5'b11xxx so their low three bits are funct3.
  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_SUB    = 5'b00001,
    OP_AND    = 5'b00010,
    OP_OR     = 5'b00011,
    OP_XOR    = 5'b00100,
    OP_SLL    = 5'b00101,
    OP_SRL    = 5'b00110,
    OP_SRA    = 5'b00111,
    OP_SLT    = 5'b01000,
    OP_SLTU   = 5'b01001,
    OP_MUL    = 5'b11000,
    OP_MULH   = 5'b11001,
    OP_MULHSU = 5'b11010,
    OP_MULHU  = 5'b11011,
    OP_DIV    = 5'b11100,
    OP_DIVU   = 5'b11101,
    OP_REM    = 5'b11110,
    OP_REMU   = 5'b11111
  } operation_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_e;

  function automatic logic is_muldiv(input operation_e op);
    return op[4:3] == 2'b11;
  endfunction

  function automatic muldiv_op_e to_muldiv_op(input operation_e op);
    return muldiv_op_e'(op[2:0]);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the RISC-V M extension:
// magnitude shift-add / restoring divide, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  riscv_pkg::muldiv_op_e  op_i,
  input  logic [XLEN-1:0]        a_i,
  input  logic [XLEN-1:0]        b_i,
  input  logic [4:0]             rd_addr_i,
  input  logic                   flush_i,
  output logic                   ready_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [XLEN-1:0]        result_o,
  output logic [4:0]             rd_addr_o
);

  import riscv_pkg::*;

  localparam int CW = $clog2(XLEN);

  md_state_e         r_state;
  md_state_e         w_next;
  muldiv_op_e        r_op;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd;
  logic              r_a_neg;
  logic              r_b_neg;
  logic              r_div0;

  logic              w_accept;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_special;
  logic [XLEN-1:0]   w_fix;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_prod;

  assign ready_o   = (r_state == IDLE) || (r_state == DONE);
  assign busy_o    = (r_state == CALC) || (r_state == FIX);
  assign done_o    = (r_state == DONE);
  assign result_o  = r_result;
  assign rd_addr_o = r_rd;
  assign w_accept  = valid_i && ready_o && !flush_i;

  always_comb begin
    w_a_signed = op_i inside {MUL, MULH, MULHSU, DIV, REM};
    w_b_signed = op_i inside {MUL, MULH, DIV, REM};
    w_a_neg    = w_a_signed && a_i[XLEN-1];
    w_b_neg    = w_b_signed && b_i[XLEN-1];
    w_a_mag    = w_a_neg ? -a_i : a_i;
    w_b_mag    = w_b_neg ? -b_i : b_i;
    w_div0     = op_i[2] && (b_i == '0);
    w_ovf      = (op_i inside {DIV, REM}) && (a_i == {1'b1, {(XLEN-1){1'b0}}})
                 && (b_i == '1);
    w_fast     = FAST_SPECIAL && (w_div0 || w_ovf);
    w_special  = '0;
    if (w_div0)
      w_special = (op_i inside {DIV, DIVU}) ? '1 : a_i;
    else if (w_ovf)
      w_special = (op_i == DIV) ? a_i : '0;
  end

  // One radix-2 step: {r_hi,r_lo} is the product for multiply and {remainder,quotient} for divide.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_b};
    w_prod  = (r_a_neg ^ r_b_neg) ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_fix   = '0;
    case (r_op)
      MUL:                  w_fix = w_prod[XLEN-1:0];
      MULH, MULHSU, MULHU:  w_fix = w_prod[2*XLEN-1:XLEN];
      DIV, DIVU:            w_fix = r_div0 ? '1 : ((r_a_neg ^ r_b_neg) ? -r_lo : r_lo);
      REM, REMU:            w_fix = r_a_neg ? -r_hi : r_hi;
      default:              w_fix = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_next = w_fast ? DONE : CALC;
        CALC:    if (r_cnt == '0) w_next = FIX;
        FIX:     w_next = DONE;
        DONE:    w_next = w_accept ? (w_fast ? DONE : CALC) : IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op     <= MUL;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_rd     <= '0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_div0   <= 1'b0;
    end else if (w_accept) begin
      r_op     <= op_i;
      r_rd     <= rd_addr_i;
      r_a_neg  <= w_a_neg;
      r_b_neg  <= w_b_neg;
      r_div0   <= w_div0;
      r_hi     <= '0;
      r_lo     <= w_a_mag;
      r_b      <= w_b_mag;
      r_cnt    <= CW'(XLEN-1);
      r_result <= w_fast ? w_special : '0;
    end else if (!flush_i) begin
      if (r_state == CALC) begin
        if (r_op[2]) begin
          r_hi <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
        end else begin
          r_hi <= w_sum[XLEN:1];
          r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
        end
        if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      end else if (r_state == FIX) begin
        r_result <= w_fix;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32, FAST_SPECIAL=1): vector table
// plus hand sequences for back-to-back issue, flush and mid-operation reset.
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        flush;
  muldiv_op_e  opIn;
  logic [31:0] aIn;
  logic [31:0] bIn;
  logic [4:0]  rdIn;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rdOut;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    muldiv_op_e  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          lat;
    logic [31:0] res;
  } vecT;

  vecT vecs[$];

  muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (valid),
    .op_i      (opIn),
    .a_i       (aIn),
    .b_i       (bIn),
    .rd_addr_i (rdIn),
    .flush_i   (flush),
    .ready_o   (ready),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .rd_addr_o (rdOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Presents an operation during the current cycle; returns at the negedge of cycle 1.
  task automatic applyStimulus(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    opIn  = op;
    aIn   = a;
    bIn   = b;
    rdIn  = rd;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Counts cycles to done_o; optionally pokes a stray request mid-flight to prove it is ignored.
  task automatic waitDone(input int expLat, input logic [31:0] expRes, input logic [4:0] expRd,
                          input int injectAt, input string name);
    int n;
    bit busyOk;
    n = 1;
    busyOk = 1'b1;
    while (done !== 1'b1 && n < 200) begin
      if (busy !== 1'b1 || ready !== 1'b0) busyOk = 1'b0;
      @(negedge clk);
      n++;
      if (n == injectAt) begin
        valid = 1'b1;
        opIn  = DIVU;
        aIn   = 32'd1;
        bIn   = 32'd0;
        rdIn  = 5'd17;
      end else begin
        valid = 1'b0;
      end
    end
    valid = 1'b0;
    checkOutput({name, "_latency"}, 64'(n), 64'(expLat));
    if (expLat > 1) checkOutput({name, "_busy"}, 64'(busyOk), 64'd1);
    checkOutput({name, "_result"}, 64'(result), 64'(expRes));
    checkOutput({name, "_rd"}, 64'(rdOut), 64'(expRd));
  endtask

  initial begin
    bit sawDone;
    rst   = 1'b1;
    valid = 1'b0;
    flush = 1'b0;
    opIn  = MUL;
    aIn   = '0;
    bIn   = '0;
    rdIn  = '0;

    vecs.push_back('{MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  34, 32'hFFFFFFEB});
    vecs.push_back('{MULH,   32'h80000000, 32'h80000000, 5'd2,  34, 32'h40000000});
    vecs.push_back('{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  34, 32'hFFFFFFFE});
    vecs.push_back('{MULHSU, 32'hFFFFFFFF, 32'd2,        5'd4,  34, 32'hFFFFFFFF});
    vecs.push_back('{MULHU,  32'h80000000, 32'd4,        5'd5,  34, 32'd2});
    vecs.push_back('{MUL,    32'h12345678, 32'h10,       5'd6,  34, 32'h23456780});
    vecs.push_back('{MULH,   32'hFFFFFFFF, 32'd3,        5'd7,  34, 32'hFFFFFFFF});
    vecs.push_back('{DIV,    32'h80000000, 32'hFFFFFFFF, 5'd8,  1,  32'h80000000});
    vecs.push_back('{REM,    32'h80000000, 32'hFFFFFFFF, 5'd9,  1,  32'd0});
    vecs.push_back('{DIVU,   32'd100,      32'd0,        5'd10, 1,  32'hFFFFFFFF});
    vecs.push_back('{REMU,   32'd100,      32'd0,        5'd11, 1,  32'd100});
    vecs.push_back('{DIV,    32'hFFFFFFFB, 32'd0,        5'd12, 1,  32'hFFFFFFFF});
    vecs.push_back('{REM,    32'hFFFFFFF9, 32'd0,        5'd13, 1,  32'hFFFFFFF9});
    vecs.push_back('{DIVU,   32'd100,      32'd7,        5'd14, 34, 32'd14});
    vecs.push_back('{REMU,   32'd100,      32'd7,        5'd15, 34, 32'd2});
    vecs.push_back('{DIV,    32'd7,        32'hFFFFFFFE, 5'd16, 34, 32'hFFFFFFFD});
    vecs.push_back('{REM,    32'd7,        32'hFFFFFFFE, 5'd18, 34, 32'd1});

    repeat (3) @(negedge clk);
    checkOutput("reset_ready",  64'(ready),  64'd1);
    checkOutput("reset_busy",   64'(busy),   64'd0);
    checkOutput("reset_done",   64'(done),   64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_rd",     64'(rdOut),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      waitDone(vecs[i].lat, vecs[i].res, vecs[i].rd, 0, $sformatf("vec%0d", i));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_single_done", i), 64'(done), 64'd0);
      checkOutput($sformatf("vec%0d_hold", i), 64'(result), 64'(vecs[i].res));
      checkOutput($sformatf("vec%0d_idle_ready", i), 64'(ready), 64'd1);
    end

    // Second request issued in the done_o cycle of the first.
    applyStimulus(DIV, 32'hFFFFFFF9, 32'd2, 5'd3);
    waitDone(34, 32'hFFFFFFFD, 5'd3, 0, "b2b_div");
    applyStimulus(REM, 32'hFFFFFFF9, 32'd2, 5'd4);
    waitDone(34, 32'hFFFFFFFF, 5'd4, 0, "b2b_rem");
    @(negedge clk);

    // Flush a divide in cycle 10.
    applyStimulus(DIVU, 32'd1000, 32'd3, 5'd5);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_ready", 64'(ready), 64'd1);
    checkOutput("flush_busy",  64'(busy),  64'd0);
    sawDone = done;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("flush_no_done", 64'(sawDone), 64'd0);
    applyStimulus(MUL, 32'd3, 32'd5, 5'd9);
    waitDone(34, 32'd15, 5'd9, 5, "post_flush_mul");
    @(negedge clk);

    // Reset pulse in cycle 20 of a multiply.
    applyStimulus(MUL, 32'd6, 32'd7, 5'd12);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_done",   64'(done),   64'd0);
    checkOutput("midrst_busy",   64'(busy),   64'd0);
    checkOutput("midrst_result", 64'(result), 64'd0);
    checkOutput("midrst_rd",     64'(rdOut),  64'd0);
    checkOutput("midrst_ready",  64'(ready),  64'd1);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("midrst_no_done", 64'(sawDone), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter FAST_SPECIAL, default 1; 1 means divide-by-zero and signed overflow complete without iteration.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, as follows:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have the remaining ports:
- valid_i  in  1  operation request.
- op_i  in  muldiv_op_e (3 bits)  one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- a_i  in  XLEN  rs1 operand.
- b_i  in  XLEN  rs2 operand.
- rd_addr_i  in  5  destination register.
- flush_i  in  1  kills any in-flight operation.
- ready_o  out  1  request can be accepted this cycle.
- busy_o  out  1  operation in flight; drives the pipeline stall.
- done_o  out  1  one-cycle result strobe.
- result_o  out  XLEN  result, valid while done_o is high.
- rd_addr_o  out  5  destination captured at accept.

Function
REQ-005 SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-006 SHALL set ready_o high in IDLE and in DONE, and low otherwise; busy_o SHALL equal (state==CALC or state==FIX).
REQ-007 SHALL accept an operation on an edge where valid_i=1, ready_o=1 and flush_i=0; a_i, b_i, op_i and rd_addr_i SHALL be registered at that edge.
REQ-008 SHALL ignore valid_i whenever ready_o=0; there is no queueing.
REQ-009 SHALL, on a normal accept, go to CALC with the iteration counter at XLEN-1; SHALL do one radix-2 step per cycle (shift-add for multiply, restoring for divide) on operand magnitudes; SHALL go CALC->FIX when the counter reaches 0; SHALL go FIX->DONE unconditionally.
REQ-010 SHALL apply sign correction in FIX: negate the product if the operand signs differ (for MULHSU, b is unsigned); quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-011 SHALL use a 2*XLEN-bit product; MUL returns bits [XLEN-1:0]; MULH, MULHSU and MULHU return bits [2XLEN-1:XLEN].
REQ-012 SHALL, for an accept at cycle 0, raise done_o in cycle XLEN+2 (cycle 34 when XLEN=32), for exactly one cycle.
REQ-013 SHALL, when FAST_SPECIAL=1, send divide-by-zero and signed overflow straight to DONE, with done_o in cycle 1:
- Divide-by-zero: DIV/DIVU return all-ones; REM/REMU return a.
- Signed overflow (a=MIN, b=-1): DIV returns MIN; REM returns 0.
REQ-014 SHALL, when FAST_SPECIAL=0, produce the same special-case values at the normal latency.
REQ-015 SHALL hold result_o and rd_addr_o stable from done_o until the next accept, and SHALL zero result_o otherwise.
REQ-016 SHALL, in DONE, allow a new accept on the same edge that leaves DONE (back-to-back); otherwise DONE->IDLE.
REQ-017 SHALL, when flush_i=1 in any state, go to IDLE on the next edge with no done_o, and SHALL not accept a request in that cycle; flush_i in DONE SHALL suppress nothing already emitted.
REQ-018 SHALL give the counter ceil(log2(XLEN)) bits, with no wrap beyond 0.

Reset
REQ-019 SHALL, on rst_i, take the state to IDLE and clear the counter, operand registers, done_o, busy_o, result_o and rd_addr_o to 0, with ready_o=1.
REQ-020 SHALL, if reset is asserted mid-operation, abandon the operation with no done_o after reset is released.

Structure
REQ-021 SHALL place muldiv_op_e (encoded as funct3) and XLEN in riscv_pkg; the operation_e decode entries for the M-extension SHALL map onto it there.
REQ-022 SHALL be a single module with no sub-module; the FSM and datapath are co-located.

Verification (XLEN=32, FAST_SPECIAL=1)
REQ-023 SHALL check MUL a=7, b=0xFFFFFFFD: result 0xFFFFFFEB, done_o only in cycle 34, busy_o high for cycles 1-33.
REQ-024 SHALL check MULH a=b=0x80000000 -> 0x40000000, and MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-025 SHALL check the special cases, each with done_o in cycle 1:
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, and REM -> 0.
- DIVU a=100, b=0 -> 0xFFFFFFFF, and REMU -> 100.
REQ-026 SHALL check DIV a=-7, b=2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, issued back-to-back in the done_o cycle: the second done_o appears 34 cycles after the first.
REQ-027 SHALL check flush_i in cycle 10 of a DIVU: no done_o, ready_o=1 in cycle 11, and a new MUL 3*5 gives 15.
REQ-028 SHALL check rst_i pulsed in cycle 20 of a MUL: all outputs 0 immediately; no done_o for 40 cycles afterwards.
